// File: rtl/div_issue_ctrl.sv
// div_issue_ctrl: issue sequencer between EXE and the signed/unsigned stream dividers.
// Latches one div/mod request, drives the selected core's input handshakes, and
// captures the quotient or remainder. It holds that value until EXE consumes it.
// A flush while the core is busy drains the in-flight result and drops it.
// Optional feature macro: DIV_ZERO_BYPASS_EN. It answers x/0 locally without using a core.
module div_issue_ctrl #(
    parameter int unsigned DATA_W = 32,
    parameter int unsigned OUT_W  = 64
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              flush,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_signed,
    input  logic              req_mod,
    input  logic [DATA_W-1:0] req_src1,
    input  logic [DATA_W-1:0] req_src2,
    output logic              res_valid,
    input  logic              res_ready,
    output logic [DATA_W-1:0] res_data,
    output logic              busy,
    output logic [DATA_W-1:0] div_dividend_tdata,
    output logic [DATA_W-1:0] div_divisor_tdata,
    output logic              sdiv_dividend_tvalid,
    output logic              sdiv_divisor_tvalid,
    input  logic              sdiv_dividend_tready,
    input  logic              sdiv_divisor_tready,
    input  logic              sdiv_dout_tvalid,
    input  logic [OUT_W-1:0]  sdiv_dout_tdata,
    output logic              udiv_dividend_tvalid,
    output logic              udiv_divisor_tvalid,
    input  logic              udiv_dividend_tready,
    input  logic              udiv_divisor_tready,
    input  logic              udiv_dout_tvalid,
    input  logic [OUT_W-1:0]  udiv_dout_tdata
);

`ifdef DIV_ZERO_BYPASS_EN
    localparam bit ZERO_BYPASS = 1'b1;
`else
    localparam bit ZERO_BYPASS = 1'b0;
`endif

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ISSUE = 2'd1,
        S_WAIT  = 2'd2,
        S_DONE  = 2'd3
    } state_e;

    state_e              state_q;
    logic                killed_q;
    logic                signed_q;
    logic                mod_q;
    logic [DATA_W-1:0]   dividend_q;
    logic [DATA_W-1:0]   divisor_q;
    logic [DATA_W-1:0]   res_q;
    logic                res_valid_q;
    logic                sdvd_v_q;
    logic                sdvs_v_q;
    logic                udvd_v_q;
    logic                udvs_v_q;

    logic                dvd_pend_c;
    logic                dvs_pend_c;
    logic                dout_v_c;
    logic [OUT_W-1:0]    dout_c;
    logic [DATA_W-1:0]   res_sel_c;

    // Channel still pending after this cycle's handshake; result mux for the selected core
    always_comb begin
        dvd_pend_c = (sdvd_v_q & ~sdiv_dividend_tready) | (udvd_v_q & ~udiv_dividend_tready);
        dvs_pend_c = (sdvs_v_q & ~sdiv_divisor_tready)  | (udvs_v_q & ~udiv_divisor_tready);
        dout_v_c   = signed_q ? sdiv_dout_tvalid : udiv_dout_tvalid;
        dout_c     = signed_q ? sdiv_dout_tdata  : udiv_dout_tdata;
        res_sel_c  = mod_q ? dout_c[DATA_W-1:0] : dout_c[OUT_W-1:DATA_W];
    end

    // Sequencer: accept, issue both channels, wait for the core, hold result
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= S_IDLE;
            killed_q    <= 1'b0;
            signed_q    <= 1'b0;
            mod_q       <= 1'b0;
            dividend_q  <= '0;
            divisor_q   <= '0;
            res_q       <= '0;
            res_valid_q <= 1'b0;
            sdvd_v_q    <= 1'b0;
            sdvs_v_q    <= 1'b0;
            udvd_v_q    <= 1'b0;
            udvs_v_q    <= 1'b0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (req_valid && !flush) begin
                        signed_q   <= req_signed;
                        mod_q      <= req_mod;
                        dividend_q <= req_src1;
                        divisor_q  <= req_src2;
                        killed_q   <= 1'b0;
                        if (ZERO_BYPASS && (req_src2 == '0)) begin
                            res_q       <= req_mod ? req_src1 : '0;
                            res_valid_q <= 1'b1;
                            state_q     <= S_DONE;
                        end else begin
                            sdvd_v_q <= req_signed;
                            sdvs_v_q <= req_signed;
                            udvd_v_q <= ~req_signed;
                            udvs_v_q <= ~req_signed;
                            state_q  <= S_ISSUE;
                        end
                    end
                end
                S_ISSUE: begin
                    // tvalid is never withdrawn early, even when killed
                    sdvd_v_q <= sdvd_v_q & ~sdiv_dividend_tready;
                    sdvs_v_q <= sdvs_v_q & ~sdiv_divisor_tready;
                    udvd_v_q <= udvd_v_q & ~udiv_dividend_tready;
                    udvs_v_q <= udvs_v_q & ~udiv_divisor_tready;
                    if (!dvd_pend_c && !dvs_pend_c) begin
                        state_q <= S_WAIT;
                    end
                    if (flush) begin
                        killed_q <= 1'b1;
                    end
                end
                S_WAIT: begin
                    if (dout_v_c) begin
                        if (killed_q || flush) begin
                            killed_q <= 1'b0;
                            state_q  <= S_IDLE;
                        end else begin
                            res_q       <= res_sel_c;
                            res_valid_q <= 1'b1;
                            state_q     <= S_DONE;
                        end
                    end else if (flush) begin
                        killed_q <= 1'b1;
                    end
                end
                S_DONE: begin
                    if (flush || res_ready) begin
                        res_valid_q <= 1'b0;
                        state_q     <= S_IDLE;
                    end
                end
                default: begin
                    state_q <= S_IDLE;
                end
            endcase
        end
    end

    // Output wiring
    assign req_ready            = (state_q == S_IDLE) & ~flush;
    assign busy                 = (state_q != S_IDLE);
    assign res_valid            = res_valid_q;
    assign res_data             = res_q;
    assign div_dividend_tdata   = dividend_q;
    assign div_divisor_tdata    = divisor_q;
    assign sdiv_dividend_tvalid = sdvd_v_q;
    assign sdiv_divisor_tvalid  = sdvs_v_q;
    assign udiv_dividend_tvalid = udvd_v_q;
    assign udiv_divisor_tvalid  = udvs_v_q;

endmodule

// File: tb/tb_div_issue_ctrl.sv
// Bench for div_issue_ctrl: stream-core models plus a transaction-level reference.
module tb_div_issue_ctrl;

`ifdef DIV_ZERO_BYPASS_EN
    localparam bit BYP = 1'b1;
`else
    localparam bit BYP = 1'b0;
`endif

    logic        clk = 1'b0;
    always #5 clk = ~clk;

    logic        reset, flush, req_valid, req_ready, req_signed, req_mod;
    logic [31:0] req_src1, req_src2;
    logic        res_valid, res_ready, busy;
    logic [31:0] res_data, div_dividend_tdata, div_divisor_tdata;
    logic        sdiv_dividend_tvalid, sdiv_divisor_tvalid, udiv_dividend_tvalid, udiv_divisor_tvalid;

    // index 0 = unsigned core, 1 = signed core
    logic [1:0]  rdy_dvd = 2'b00, rdy_dvs = 2'b00, dout_v = 2'b00;
    logic [63:0] dout_d [2];
    logic [1:0]  tv_dvd, tv_dvs;
    assign tv_dvd = {sdiv_dividend_tvalid, udiv_dividend_tvalid};
    assign tv_dvs = {sdiv_divisor_tvalid, udiv_divisor_tvalid};

    div_issue_ctrl dut (
        .clk(clk), .reset(reset), .flush(flush),
        .req_valid(req_valid), .req_ready(req_ready), .req_signed(req_signed), .req_mod(req_mod),
        .req_src1(req_src1), .req_src2(req_src2),
        .res_valid(res_valid), .res_ready(res_ready), .res_data(res_data), .busy(busy),
        .div_dividend_tdata(div_dividend_tdata), .div_divisor_tdata(div_divisor_tdata),
        .sdiv_dividend_tvalid(sdiv_dividend_tvalid), .sdiv_divisor_tvalid(sdiv_divisor_tvalid),
        .sdiv_dividend_tready(rdy_dvd[1]), .sdiv_divisor_tready(rdy_dvs[1]),
        .sdiv_dout_tvalid(dout_v[1]), .sdiv_dout_tdata(dout_d[1]),
        .udiv_dividend_tvalid(udiv_dividend_tvalid), .udiv_divisor_tvalid(udiv_divisor_tvalid),
        .udiv_dividend_tready(rdy_dvd[0]), .udiv_divisor_tready(rdy_dvs[0]),
        .udiv_dout_tvalid(dout_v[0]), .udiv_dout_tdata(dout_d[0])
    );

    int n_tests = 0;
    int n_fail  = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Arithmetic reference {quotient, remainder}; x/0 from a core gives all-ones and the dividend
    function automatic logic [63:0] div_ref(input bit s, input logic [31:0] a, input logic [31:0] b);
        longint sa, sb;
        logic signed [63:0] q, r;
        if (b == 32'd0) return {32'hFFFF_FFFF, a};
        sa = s ? longint'($signed(a)) : longint'({32'd0, a});
        sb = s ? longint'($signed(b)) : longint'({32'd0, b});
        q = sa / sb;
        r = sa % sb;
        return {q[31:0], r[31:0]};
    endfunction

    function automatic logic [31:0] exp_res(input bit s, input bit m, input logic [31:0] a, input logic [31:0] b);
        logic [63:0] qr;
        if (BYP && b == 32'd0) return m ? a : 32'd0;
        qr = div_ref(s, a, b);
        return m ? qr[31:0] : qr[63:32];
    endfunction

    // Reference model state: one operation in flight at transaction level
    bit          m_active, m_signed, m_mod, m_pend_a, m_pend_b, m_have_res, m_discard;
    logic [31:0] m_a, m_b, m_res;
    int          cnt_dvd, cnt_dvs, cnt_tv_s, cnt_tv_u;

    // Core model controls
    bit ready_high = 1'b1;
    bit spur_en    = 1'b0;
    int lat_min = 2, lat_max = 2, hold_dvd = 0;

    // Stream divider cores: capture both operands, answer after a latency, inject stray dout pulses
    always begin : core_model
        logic [1:0]  nv;
        logic [63:0] nd [2];
        logic [1:0]  c_run, c_ga, c_gb;
        int          c_cnt [2];
        logic [31:0] c_a [2], c_b [2];
        @(posedge clk);
        for (int c = 0; c < 2; c++) begin
            nv[c] = 1'b0;
            nd[c] = dout_d[c];
            if (reset) begin
                c_run[c] = 1'b0; c_ga[c] = 1'b0; c_gb[c] = 1'b0; c_cnt[c] = 0;
            end else begin
                if (c_run[c]) begin
                    if (c_cnt[c] == 0) begin
                        nv[c] = 1'b1;
                        nd[c] = div_ref(c == 1, c_a[c], c_b[c]);
                        c_run[c] = 1'b0;
                    end else begin
                        c_cnt[c]--;
                    end
                end
                if (tv_dvd[c] && rdy_dvd[c]) begin c_ga[c] = 1'b1; c_a[c] = div_dividend_tdata; end
                if (tv_dvs[c] && rdy_dvs[c]) begin c_gb[c] = 1'b1; c_b[c] = div_divisor_tdata; end
                if (c_ga[c] && c_gb[c]) begin
                    c_run[c] = 1'b1; c_ga[c] = 1'b0; c_gb[c] = 1'b0;
                    c_cnt[c] = int'($urandom_range(lat_max, lat_min));
                end
                if (spur_en && !c_run[c] && !nv[c] && !c_ga[c] && !c_gb[c] && m_active
                    && (m_signed != 1'(c)) && ($urandom % 8 == 0)) begin
                    nv[c] = 1'b1;
                    nd[c] = {$urandom, $urandom};
                end
            end
        end
        #1;
        dout_v = nv;
        dout_d[0] = nd[0];
        dout_d[1] = nd[1];
        for (int c = 0; c < 2; c++) begin
            rdy_dvd[c] = ready_high ? 1'b1 : ($urandom % 3 != 0);
            rdy_dvs[c] = ready_high ? 1'b1 : ($urandom % 3 != 0);
        end
        if (hold_dvd > 0 && (|tv_dvd)) begin
            rdy_dvd = 2'b00;
            hold_dvd--;
        end
    end

    // Per-cycle compare against the reference, then advance the reference
    always @(negedge clk) begin
        if (reset) begin
            m_active = 0; m_pend_a = 0; m_pend_b = 0; m_have_res = 0; m_discard = 0;
        end else begin
            chk("busy", 32'(busy), 32'(m_active));
            chk("req_ready", 32'(req_ready), 32'(!m_active && !flush));
            chk("res_valid", 32'(res_valid), 32'(m_have_res));
            if (m_have_res) chk("res_data", res_data, m_res);
            chk("s_dvd_tvalid", 32'(sdiv_dividend_tvalid), 32'(m_active && m_signed && m_pend_a));
            chk("s_dvs_tvalid", 32'(sdiv_divisor_tvalid), 32'(m_active && m_signed && m_pend_b));
            chk("u_dvd_tvalid", 32'(udiv_dividend_tvalid), 32'(m_active && !m_signed && m_pend_a));
            chk("u_dvs_tvalid", 32'(udiv_divisor_tvalid), 32'(m_active && !m_signed && m_pend_b));
            if (m_active && (m_pend_a || m_pend_b)) begin
                chk("dividend_tdata", div_dividend_tdata, m_a);
                chk("divisor_tdata", div_divisor_tdata, m_b);
            end
            if (|tv_dvd) cnt_dvd++;
            if (|tv_dvs) cnt_dvs++;
            if (sdiv_dividend_tvalid || sdiv_divisor_tvalid) cnt_tv_s++;
            if (udiv_dividend_tvalid || udiv_divisor_tvalid) cnt_tv_u++;

            if (!m_active) begin
                if (req_valid && !flush) begin
                    m_active = 1; m_signed = req_signed; m_mod = req_mod;
                    m_a = req_src1; m_b = req_src2; m_discard = 0;
                    if (BYP && req_src2 == 32'd0) begin
                        m_have_res = 1; m_res = exp_res(req_signed, req_mod, req_src1, req_src2);
                        m_pend_a = 0; m_pend_b = 0;
                    end else begin
                        m_pend_a = 1; m_pend_b = 1;
                    end
                end
            end else if (m_pend_a || m_pend_b) begin
                if (m_pend_a && rdy_dvd[m_signed]) m_pend_a = 0;
                if (m_pend_b && rdy_dvs[m_signed]) m_pend_b = 0;
                if (flush) m_discard = 1;
            end else if (!m_have_res) begin
                if (dout_v[m_signed]) begin
                    if (m_discard || flush) begin
                        m_active = 0; m_discard = 0;
                    end else begin
                        m_have_res = 1; m_res = exp_res(m_signed, m_mod, m_a, m_b);
                    end
                end else if (flush) begin
                    m_discard = 1;
                end
            end else if (flush || res_ready) begin
                m_active = 0; m_have_res = 0;
            end
        end
    end

    task automatic do_accept(input bit s, input bit m, input logic [31:0] a, input logic [31:0] b, input string name);
        bit ok = 0;
        @(posedge clk); #1;
        req_valid = 1; req_signed = s; req_mod = m; req_src1 = a; req_src2 = b;
        for (int i = 0; i < 40 && !ok; i++) begin
            @(negedge clk);
            if (req_ready) ok = 1;
        end
        if (!ok) chk({name, "_accept_timeout"}, 32'd0, 32'd1);
        @(posedge clk); #1;
        req_valid = 0;
    endtask

    // One directed operation with a hand-computed expected result; stall = cycles res_ready held low
    task automatic run_op(input bit s, input bit m, input logic [31:0] a, input logic [31:0] b,
                          input logic [31:0] exp, input string name, input int stall);
        bit got = 0;
        res_ready = (stall == 0);
        do_accept(s, m, a, b, name);
        for (int i = 0; i < 100 && !got; i++) begin
            @(negedge clk);
            if (res_valid) got = 1;
        end
        if (!got) chk({name, "_res_timeout"}, 32'd0, 32'd1);
        chk(name, res_data, exp);
        if (stall > 0) begin
            for (int k = 0; k < stall; k++) begin
                @(negedge clk);
                chk({name, "_hold_valid"}, 32'(res_valid), 32'd1);
                chk({name, "_hold_data"}, res_data, exp);
            end
            @(posedge clk); #1;
            res_ready = 1;
            @(negedge clk);
        end
        @(negedge clk);
        chk({name, "_idle_after"}, 32'({busy, res_valid}), 32'd0);
    endtask

    initial begin
        int seen;
        reset = 1; flush = 0; req_valid = 0; req_signed = 0; req_mod = 0;
        req_src1 = 0; req_src2 = 0; res_ready = 1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_res_valid", 32'(res_valid), 32'd0);
        chk("rst_res_data", res_data, 32'd0);
        chk("rst_tvalids", 32'({tv_dvd, tv_dvs}), 32'd0);
        chk("rst_tdata", div_dividend_tdata | div_divisor_tdata, 32'd0);
        @(posedge clk); #1;
        reset = 0;

        run_op(1, 0, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFD, "sdiv_m7_2", 0);
        run_op(1, 1, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF, "smod_m7_2", 0);

        cnt_tv_s = 0; cnt_tv_u = 0;
        run_op(0, 1, 32'hFFFF_FFFF, 32'd16, 32'h0000_000F, "umod_ff_16", 0);
        chk("umod_no_sdiv_tvalid", 32'(cnt_tv_s), 32'd0);
        chk("umod_udiv_tvalid", 32'(cnt_tv_u != 0), 32'd1);

        hold_dvd = 3; cnt_dvd = 0; cnt_dvs = 0;
        run_op(0, 0, 32'd100, 32'd7, 32'd14, "hold_dvd", 0);
        chk("hold_dvd_cycles", 32'(cnt_dvd), 32'd4);
        chk("hold_dvs_cycles", 32'(cnt_dvs), 32'd1);

        run_op(0, 0, 32'd7, 32'd2, 32'd3, "stall_7_2", 5);

        // Flush while waiting on a slow core, then a clean follow-up
        lat_min = 8; lat_max = 8;
        do_accept(0, 0, 32'd100, 32'd7, "flush_op");
        @(posedge clk); #1;
        flush = 1;
        @(posedge clk); #1;
        flush = 0;
        seen = 0;
        for (int i = 0; i < 50 && busy; i++) begin
            @(negedge clk);
            if (res_valid) seen++;
        end
        chk("flush_no_res", 32'(seen), 32'd0);
        chk("flush_drained", 32'(busy), 32'd0);
        lat_min = 2; lat_max = 2;
        run_op(0, 0, 32'd100, 32'd9, 32'd11, "after_flush", 0);

        cnt_tv_s = 0;
        run_op(1, 0, 32'd5, 32'd0, BYP ? 32'd0 : 32'hFFFF_FFFF, "divzero", 0);
        chk("divzero_core_tvalid", 32'(cnt_tv_s != 0), BYP ? 32'd0 : 32'd1);

        // Randomized traffic with back-pressure, stray core pulses and flushes
        ready_high = 0; lat_min = 0; lat_max = 4; spur_en = 1;
        for (int cyc = 0; cyc < 4000; cyc++) begin
            @(posedge clk); #1;
            req_valid  = ($urandom % 2) == 0;
            req_signed = $urandom % 2;
            req_mod    = $urandom % 2;
            req_src1   = ($urandom % 8 == 0) ? 32'h8000_0000 : $urandom;
            case ($urandom % 8)
                0: req_src2 = 32'd0;
                1: req_src2 = 32'd1;
                2: req_src2 = 32'hFFFF_FFFF;
                3: req_src2 = $urandom % 16;
                default: req_src2 = $urandom;
            endcase
            flush     = ($urandom % 24) == 0;
            res_ready = ($urandom % 4) != 0;
        end
        @(posedge clk); #1;
        req_valid = 0; flush = 0; res_ready = 1;
        for (int i = 0; i < 100 && busy; i++) @(negedge clk);
        chk("quiesce", 32'(busy), 32'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
